// File: rtl/sync_fifo_fwft_pkg.sv
// Shared sizing helpers for the FWFT FIFO slice.
// Pure constants/functions, no timing or flow-control behaviour.
// Imported by the interface, the top and the pointer/storage helpers.
package sync_fifo_fwft_pkg;

   localparam int FIFO_ADDR_ZERO = 0;

   // Occupancy and pointers need one bit beyond the address to reach Depth.
   function automatic int fifo_count_w(input int log_depth);
      return log_depth + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle between a FWFT FIFO and its producer/consumer.
// Wires only, no latency.
// Backpressure carried by full/almost_full; availability by r_valid.
interface sync_fifo_fwft_if
   import sync_fifo_fwft_pkg::*;
#(
   parameter type T        = logic,
   parameter int  LogDepth = 4
);
   localparam int CntW = fifo_count_w(LogDepth);

   logic            flush;
   logic            push;
   T                w_data;
   logic            full;
   logic            almost_full;
   logic            pop;
   T                r_data;
   logic            r_valid;
   logic            almost_empty;
   logic [CntW-1:0] count;
   logic [CntW-1:0] af_thresh;
   logic [CntW-1:0] ae_thresh;
   logic            overflow;
   logic            underflow;

   modport master (
      output flush, push, w_data, pop, af_thresh, ae_thresh,
      input  full, almost_full, r_data, r_valid, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, push, w_data, pop, af_thresh, ae_thresh,
      output full, almost_full, r_data, r_valid, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/counter.sv
// Wrapping up-counter with synchronous clear, used for FIFO pointers.
// Increments on the edge after inc; clear takes priority.
// No backpressure; caller gates inc.
module counter
   import sync_fifo_fwft_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= W'(FIFO_ADDR_ZERO);
      else if (clr) q <= W'(FIFO_ADDR_ZERO);
      else if (inc) q <= q + W'(1);
   end
endmodule

// File: rtl/sdpram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read data appears one edge after rd_en and holds until the next rd_en.
// No backpressure; caller guarantees address validity.
module sdpram #(
   parameter type T     = logic,
   parameter int  AddrW = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AddrW-1:0] wr_addr,
   input  T                 wr_dat,
   input  logic             rd_en,
   input  logic [AddrW-1:0] rd_addr,
   output T                 rd_dat
);
   T mem [2**AddrW];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
      if (rd_en) rd_dat <= mem[rd_addr];
   end
endmodule

// File: rtl/sync_fifo_fwft_head_reg.sv
// Head-of-queue stage: valid bit, direct-write register and RAM prefetch control.
// Head refills on the same edge it is freed (from RAM or straight from w_data).
// No backpressure of its own; store/pop_acc are already qualified by the top.
module fifo_head_reg #(
   parameter type T = logic
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic store,
   input  logic pop_acc,
   input  logic ram_empty,
   input  T     w_data,
   input  T     ram_rd_dat,
   output logic head_vld,
   output T     head_dat,
   output logic ram_rd_en,
   output logic ram_wr_en
);
   logic vld_q;
   logic sel_ram_q;
   T     dat_q;
   logic head_free;
   logic load_direct;

   assign head_free   = !vld_q || pop_acc;
   assign ram_rd_en   = head_free && !ram_empty && !flush;
   // With RAM empty a freed head takes the incoming word directly, skipping the RAM.
   assign load_direct = head_free && ram_empty && store && !flush;
   assign ram_wr_en   = store && !load_direct && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= 1'b0;
         sel_ram_q <= 1'b0;
         dat_q     <= '0;
      end else if (flush) begin
         vld_q     <= 1'b0;
         sel_ram_q <= 1'b0;
         dat_q     <= '0;
      end else begin
         if (head_free) vld_q <= ram_rd_en || load_direct;
         if (ram_rd_en) begin
            sel_ram_q <= 1'b1;
         end else if (load_direct) begin
            sel_ram_q <= 1'b0;
            dat_q     <= w_data;
         end
      end
   end

   // The RAM read register doubles as head storage once an entry is prefetched.
   assign head_vld = vld_q;
   assign head_dat = sel_ram_q ? ram_rd_dat : dat_q;
endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with count, thresholds, flush, sticky error flags.
// Push to empty visible one edge later; SYNC_FIFO_FWFT_BYPASS_EN makes it same-cycle.
// Rejects push while full and pop while empty, latching overflow/underflow.
module sync_fifo_fwft
   import sync_fifo_fwft_pkg::*;
#(
   parameter type T        = logic,
   parameter int  LogDepth = 4
) (
   input logic             clk,
   input logic             rst_n,
   sync_fifo_fwft_if.slave bus
);
   localparam int Depth = 2**LogDepth;
   localparam int CntW  = fifo_count_w(LogDepth);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] wr_ptr;
   logic [CntW-1:0] rd_ptr;
   logic            push_acc;
   logic            pop_acc;
   logic            store;
   logic            ram_empty;
   logic            ram_rd_en;
   logic            ram_wr_en;
   logic            head_vld;
   logic            overflow_q;
   logic            underflow_q;
   T                head_dat;
   T                ram_rd_dat;

   assign bus.full         = (cnt_q == CntW'(Depth));
   assign bus.almost_full  = (cnt_q >= bus.af_thresh);
   assign bus.almost_empty = (cnt_q <= bus.ae_thresh);
   assign bus.count        = cnt_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

   assign push_acc = bus.push && !bus.full && !bus.flush;
   assign pop_acc  = bus.pop && bus.r_valid && !bus.flush;

`ifdef SYNC_FIFO_FWFT_BYPASS_EN
   logic byp;
   assign byp         = (cnt_q == '0) && bus.push;
   assign bus.r_valid = head_vld || byp;
   assign bus.r_data  = byp ? bus.w_data : head_dat;
   // Word consumed in the cycle it arrives never touches storage.
   assign store       = push_acc && !(byp && pop_acc);
`else
   assign bus.r_valid = head_vld;
   assign bus.r_data  = head_dat;
   assign store       = push_acc;
`endif

   assign ram_empty = (wr_ptr == rd_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.flush) begin
         cnt_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_q + CntW'(push_acc) - CntW'(pop_acc);
         overflow_q  <= overflow_q  || (bus.push && bus.full);
         underflow_q <= underflow_q || (bus.pop && !bus.r_valid);
      end
   end

   counter #(.W(CntW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush),
      .inc   (ram_wr_en),
      .q     (wr_ptr)
   );

   counter #(.W(CntW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush),
      .inc   (ram_rd_en),
      .q     (rd_ptr)
   );

   sdpram #(.T(T), .AddrW(LogDepth)) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (wr_ptr[LogDepth-1:0]),
      .wr_dat  (bus.w_data),
      .rd_en   (ram_rd_en),
      .rd_addr (rd_ptr[LogDepth-1:0]),
      .rd_dat  (ram_rd_dat)
   );

   fifo_head_reg #(.T(T)) u_head (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (bus.flush),
      .store      (store),
      .pop_acc    (pop_acc),
      .ram_empty  (ram_empty),
      .w_data     (bus.w_data),
      .ram_rd_dat (ram_rd_dat),
      .head_vld   (head_vld),
      .head_dat   (head_dat),
      .ram_rd_en  (ram_rd_en),
      .ram_wr_en  (ram_wr_en)
   );
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft (8-bit payload, 16 entries).
module tb_sync_fifo_fwft;
   import sync_fifo_fwft_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   sync_fifo_fwft_if #(.T(logic [7:0]), .LogDepth(4)) bus ();

   sync_fifo_fwft #(.T(logic [7:0]), .LogDepth(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      bus.flush     = 1'b0;
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.w_data    = 8'h00;
      bus.af_thresh = 5'd12;
      bus.ae_thresh = 5'd3;

      // Reset values, observed with no clock edge yet
      #2;
      chk("rst_count",  bus.count, 0);
      chk("rst_valid",  bus.r_valid, 0);
      chk("rst_rdata",  bus.r_data, 0);
      chk("rst_full",   bus.full, 0);
      chk("rst_ae",     bus.almost_empty, 1);
      chk("rst_af",     bus.almost_full, 0);
      chk("rst_ovf",    bus.overflow, 0);
      chk("rst_unf",    bus.underflow, 0);
      rst_n = 1'b1;
      tick();

      // 1: single push latency
      bus.push = 1'b1; bus.w_data = 8'hA1;
      #1;
`ifdef SYNC_FIFO_FWFT_BYPASS_EN
      chk("t1_byp_valid", bus.r_valid, 1);
      chk("t1_byp_data",  bus.r_data, 8'hA1);
`else
      chk("t1_no_comb_valid", bus.r_valid, 0);
`endif
      tick();
      bus.push = 1'b0;
      chk("t1_valid", bus.r_valid, 1);
      chk("t1_data",  bus.r_data, 8'hA1);
      chk("t1_count", bus.count, 1);
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      chk("t1_drain_count", bus.count, 0);
      chk("t1_drain_valid", bus.r_valid, 0);

      // 2: fill to full, then overflow
      for (int i = 0; i < 16; i++) begin
         bus.push = 1'b1; bus.w_data = 8'(8'h10 + i);
         tick();
      end
      bus.push = 1'b0;
      chk("t2_full",  bus.full, 1);
      chk("t2_count", bus.count, 16);
      chk("t2_head",  bus.r_data, 8'h10);
      chk("t2_af",    bus.almost_full, 1);
      bus.push = 1'b1; bus.w_data = 8'hEE;
      tick();
      bus.push = 1'b0;
      chk("t2_ovf",       bus.overflow, 1);
      chk("t2_ovf_count", bus.count, 16);
      chk("t2_ovf_head",  bus.r_data, 8'h10);
      bus.af_thresh = 5'd17;
      #1;
      chk("t2_af_above_depth", bus.almost_full, 0);
      bus.af_thresh = 5'd12;
      tick();
      chk("t2_ovf_sticky", bus.overflow, 1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("t2_flush_ovf",   bus.overflow, 0);
      chk("t2_flush_count", bus.count, 0);

      // 3: steady push+pop at depth 5 across the pointer wrap
      for (int i = 0; i < 5; i++) begin
         bus.push = 1'b1; bus.w_data = 8'(8'h30 + i);
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         bus.push = 1'b1; bus.pop = 1'b1; bus.w_data = 8'(8'h35 + i);
         chk("t3_valid", bus.r_valid, 1);
         chk("t3_order", bus.r_data, 32'(8'h30 + i));
         tick();
         chk("t3_count", bus.count, 5);
      end
      bus.push = 1'b0; bus.pop = 1'b0;
      chk("t3_tail_head", bus.r_data, 8'h44);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;

      // 4: threshold sweep af=12, ae=3
      chk("t4_af_0", bus.almost_full, 0);
      chk("t4_ae_0", bus.almost_empty, 1);
      for (int k = 1; k <= 16; k++) begin
         bus.push = 1'b1; bus.w_data = 8'(k);
         tick();
         chk("t4_up_af", bus.almost_full, (k >= 12) ? 1 : 0);
         chk("t4_up_ae", bus.almost_empty, (k <= 3) ? 1 : 0);
      end
      bus.push = 1'b0;
      for (int k = 15; k >= 0; k--) begin
         bus.pop = 1'b1;
         tick();
         chk("t4_dn_count", bus.count, k);
         chk("t4_dn_af", bus.almost_full, (k >= 12) ? 1 : 0);
         chk("t4_dn_ae", bus.almost_empty, (k <= 3) ? 1 : 0);
      end
      bus.pop = 1'b0;

      // 5: underflow, sticky until flush
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      chk("t5_unf",       bus.underflow, 1);
      chk("t5_unf_count", bus.count, 0);
      tick();
      chk("t5_unf_sticky", bus.underflow, 1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("t5_flush_unf",   bus.underflow, 0);
      chk("t5_flush_valid", bus.r_valid, 0);

      // 6: flush beats push+pop, then async reset mid-burst
      for (int i = 0; i < 8; i++) begin
         bus.push = 1'b1; bus.w_data = 8'(8'h50 + i);
         tick();
      end
      chk("t6_fill_count", bus.count, 8);
      bus.flush = 1'b1; bus.push = 1'b1; bus.pop = 1'b1; bus.w_data = 8'h99;
      tick();
      bus.flush = 1'b0; bus.pop = 1'b0;
      chk("t6_flush_count", bus.count, 0);
      chk("t6_flush_valid", bus.r_valid, 0);
      for (int i = 0; i < 3; i++) begin
         bus.w_data = 8'(8'h60 + i);
         tick();
      end
      chk("t6_burst_count", bus.count, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_arst_count", bus.count, 0);
      chk("t6_arst_valid", bus.r_valid, 0);
      chk("t6_arst_rdata", bus.r_data, 0);
      chk("t6_arst_full",  bus.full, 0);
      chk("t6_arst_ae",    bus.almost_empty, 1);
      bus.push = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_post_count", bus.count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
